// File: rtl/aes128_inv_cipher_iter_if.sv
// Start/done handshake and data bus of the iterative
// AES-128 decryption engine.
interface aes128_inv_cipher_iter_if;
    logic           start;
    logic [0:127]   ct_in;
    logic [0:127]   key_in;
    logic           busy;
    logic           done;
    logic [0:127]   pt_out;

    modport master (
        output start, ct_in, key_in,
        input  busy, done, pt_out
    );

    modport slave (
        input  start, ct_in, key_in,
        output busy, done, pt_out
    );
endinterface

// File: rtl/aes128_inv_cipher_iter.sv
// Iterative AES-128 decryption: one inverse round per clock,
// round keys derived backwards from the round-10 key.

module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    localparam logic [0:2047] TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };
    assign y = TBL[{a, 3'b000} +: 8];
endmodule

module aes_inv_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    localparam logic [0:2047] TBL = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };
    assign y = TBL[{a, 3'b000} +: 8];
endmodule

module aes128_inv_cipher_iter (
    input  logic                            clk,
    input  logic                            rst,
    aes128_inv_cipher_iter_if.slave         bus
);
    typedef enum logic { IDLE, RUN } state_t;

    state_t         state_q, state_d;
    logic [3:0]     r_q, r_d;
    logic [0:127]   st_q, st_d;
    logic [0:127]   kr_q, kr_d;
    logic [0:127]   pt_q, pt_d;
    logic           done_q, done_d;

    logic [0:31]    w0, w1, w2, w3;
    logic [0:31]    v0, v1, v2, v3;
    logic [0:31]    rot, sub;
    logic [0:127]   k_prev;
    logic [0:127]   sr, sb, t;

    function automatic logic [7:0] rcon(input logic [3:0] n);
        logic [7:0] c;
        c = 8'h00;
        unique case (n)
            4'd1:    c = 8'h01;
            4'd2:    c = 8'h02;
            4'd3:    c = 8'h04;
            4'd4:    c = 8'h08;
            4'd5:    c = 8'h10;
            4'd6:    c = 8'h20;
            4'd7:    c = 8'h40;
            4'd8:    c = 8'h80;
            4'd9:    c = 8'h1b;
            4'd10:   c = 8'h36;
            default: c = 8'h00;
        endcase
        return c;
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [0:127] inv_mix(input logic [0:127] s);
        logic [0:127] m;
        logic [7:0] a [4];
        logic [7:0] x2 [4];
        logic [7:0] x4 [4];
        logic [7:0] x8 [4];
        logic [7:0] e [4];
        logic [7:0] bb [4];
        logic [7:0] d [4];
        logic [7:0] n9 [4];
        m = '0;
        for (int c = 0; c < 4; c++) begin
            for (int j = 0; j < 4; j++) begin
                a[j]  = s[32*c+8*j +: 8];
                x2[j] = xt(a[j]);
                x4[j] = xt(x2[j]);
                x8[j] = xt(x4[j]);
                e[j]  = x8[j] ^ x4[j] ^ x2[j];
                bb[j] = x8[j] ^ x2[j] ^ a[j];
                d[j]  = x8[j] ^ x4[j] ^ a[j];
                n9[j] = x8[j] ^ a[j];
            end
            m[32*c    +: 8] = e[0] ^ bb[1] ^ d[2] ^ n9[3];
            m[32*c+8  +: 8] = n9[0] ^ e[1] ^ bb[2] ^ d[3];
            m[32*c+16 +: 8] = d[0] ^ n9[1] ^ e[2] ^ bb[3];
            m[32*c+24 +: 8] = bb[0] ^ d[1] ^ n9[2] ^ e[3];
        end
        return m;
    endfunction

    // Backwards key schedule: previous round key from current one.
    assign w0  = kr_q[0:31];
    assign w1  = kr_q[32:63];
    assign w2  = kr_q[64:95];
    assign w3  = kr_q[96:127];
    assign v3  = w3 ^ w2;
    assign v2  = w2 ^ w1;
    assign v1  = w1 ^ w0;
    assign rot = {v3[8:31], v3[0:7]};
    assign v0  = w0 ^ sub ^ {rcon(r_q), 24'h000000};
    assign k_prev = {v0, v1, v2, v3};

    for (genvar i = 0; i < 4; i++) begin : g_sub
        aes_sbox u_sbox (
            .a(rot[8*i +: 8]),
            .y(sub[8*i +: 8])
        );
    end

    // InvShiftRows then InvSubBytes, byte by byte.
    for (genvar i = 0; i < 16; i++) begin : g_inv
        localparam int ROW = i % 4;
        localparam int COL = i / 4;
        localparam int SRC = ROW + 4 * ((COL + 4 - ROW) % 4);
        assign sr[8*i +: 8] = st_q[8*SRC +: 8];
        aes_inv_sbox u_isbox (
            .a(sr[8*i +: 8]),
            .y(sb[8*i +: 8])
        );
    end

    assign t = sb ^ k_prev;

    assign bus.busy   = (state_q == RUN);
    assign bus.done   = done_q;
    assign bus.pt_out = pt_q;

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            r_q     <= 4'd0;
            st_q    <= '0;
            kr_q    <= '0;
            pt_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            st_q    <= st_d;
            kr_q    <= kr_d;
            pt_q    <= pt_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic: load on start, one inverse round per cycle.
    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        st_d    = st_q;
        kr_d    = kr_q;
        pt_d    = pt_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    st_d    = bus.ct_in ^ bus.key_in;
                    kr_d    = bus.key_in;
                    r_d     = 4'd10;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (r_q == 4'd1) begin
                    pt_d    = t;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    st_d = inv_mix(t);
                    kr_d = k_prev;
                    r_d  = r_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule
